// File: rtl/sub_array_stream_packer.sv
// Sub-row split tile packer: row-major element stream in, packed tile out.
// Upper SUB_ROWS rows go column-major first, then the remaining rows.
module sub_array_stream_packer #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int SUB_ROWS  = 4,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int N  = ROWS * COLS,
    localparam int OW = N * BIT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [BIT_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OW-1:0]        out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RW-1:0]        row_idx,
    output logic [CW-1:0]        col_idx
);

    localparam int SW = $clog2(N) + 1;
    localparam logic [SW-1:0] SR_W   = SW'(SUB_ROWS);
    localparam logic [SW-1:0] LR_W   = SW'(ROWS - SUB_ROWS);
    localparam logic [SW-1:0] BASE_W = SW'(COLS * SUB_ROWS);

    typedef enum logic {FILL, FULL} state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [OW-1:0]   out_q, out_d;

    logic [SW-1:0]   r_w, c_w, slot;
    logic            upper;
    logic            col_wrap, last;

    assign r_w = SW'(row_q);
    assign c_w = SW'(col_q);

    if (SUB_ROWS == 0) begin : g_no_upper
        assign upper = 1'b0;
    end else begin : g_upper
        assign upper = (r_w < SR_W);
    end

    // Slot arithmetic carries one spare bit so BASE_W never wraps.
    assign slot = upper ? (c_w * SR_W + r_w)
                        : (BASE_W + c_w * LR_W + (r_w - SR_W));

    assign col_wrap = (col_q == CW'(COLS - 1));
    assign last     = col_wrap && (row_q == RW'(ROWS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            row_q   <= '0;
            col_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        out_d   = out_q;
        if (flush) begin
            state_d = FILL;
            row_d   = '0;
            col_d   = '0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (in_valid) begin
                        for (int s = 0; s < N; s++) begin
                            if (slot == SW'(s)) begin
                                out_d[s*BIT_WIDTH +: BIT_WIDTH] = in_data;
                            end
                        end
                        if (col_wrap) begin
                            col_d = '0;
                            row_d = last ? '0 : row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                        if (last) begin
                            state_d = FULL;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == FULL);
    assign out       = out_q;
    assign row_idx   = row_q;
    assign col_idx   = col_q;

endmodule

// File: tb/tb_sub_array_stream_packer.sv
// Directed bench for sub_array_stream_packer: default tile, gaps, backpressure,
// flush, async reset and parameter variants against a golden reorder.
module tb_sub_array_stream_packer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic [3:0]   in_data;
    logic         in_valid;
    logic         out_ready;
    logic         in_ready, out_valid;
    logic [255:0] out;
    logic [2:0]   row_idx, col_idx;

    logic         in_ready0, out_valid0, in_ready8, out_valid8;
    logic [255:0] out0, out8;
    logic [2:0]   row0, col0, row8, col8;

    logic         flush_s, in_valid_s, out_ready_s;
    logic [6:0]   in_data_s;
    logic         in_ready_s, out_valid_s;
    logic [104:0] out_s;
    logic [1:0]   row_s;
    logic [2:0]   col_s;

    int total = 0;
    int bad   = 0;

    logic [6:0] mdl [64];
    logic [6:0] mdls [64];
    int         acc;
    logic       mfull;

    always #5 clk = ~clk;

    sub_array_stream_packer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .out(out),
        .out_valid(out_valid), .out_ready(out_ready),
        .row_idx(row_idx), .col_idx(col_idx)
    );

    sub_array_stream_packer #(.SUB_ROWS(0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready0), .out(out0),
        .out_valid(out_valid0), .out_ready(out_ready),
        .row_idx(row0), .col_idx(col0)
    );

    sub_array_stream_packer #(.SUB_ROWS(8)) dut_s8 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready8), .out(out8),
        .out_valid(out_valid8), .out_ready(out_ready),
        .row_idx(row8), .col_idx(col8)
    );

    sub_array_stream_packer #(
        .BIT_WIDTH(7), .ROWS(3), .COLS(5), .SUB_ROWS(1)
    ) dut_sm (
        .clk(clk), .rst_n(rst_n), .flush(flush_s), .in_data(in_data_s),
        .in_valid(in_valid_s), .in_ready(in_ready_s), .out(out_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s),
        .row_idx(row_s), .col_idx(col_s)
    );

    function automatic logic [255:0] gold(input int rows, input int cols,
                                          input int sub, input int bw,
                                          input logic [6:0] d [64]);
        logic [255:0] v;
        int s;
        v = '0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                if (r < sub) s = c * sub + r;
                else s = cols * sub + c * (rows - sub) + (r - sub);
                for (int b = 0; b < bw; b++) v[s*bw+b] = d[r*cols+c][b];
            end
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs,
                       input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_row"}, 256'(row_idx), 256'(acc / 8));
        chk({tag, "_col"}, 256'(col_idx), 256'(acc % 8));
        chk({tag, "_ovalid"}, 256'(out_valid), 256'(mfull));
        chk({tag, "_iready"}, 256'(in_ready), 256'(!mfull));
        chk({tag, "_out"}, out, gold(8, 8, 4, 4, mdl));
    endtask

    // Reference behaviour for the default instance, then one clock.
    task automatic cyc();
        if (flush) begin
            acc = 0;
            mfull = 1'b0;
        end else if (mfull) begin
            if (out_ready) mfull = 1'b0;
        end else if (in_valid) begin
            mdl[acc] = {3'b0, in_data};
            acc++;
            if (acc == 64) begin
                acc = 0;
                mfull = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        for (int i = 0; i < 64; i++) begin
            mdl[i] = '0;
            mdls[i] = '0;
        end
        acc = 0;
        mfull = 1'b0;
        rst_n = 1'b0;
        flush = 1'b0;
        in_data = '0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        flush_s = 1'b0;
        in_valid_s = 1'b0;
        in_data_s = '0;
        out_ready_s = 1'b0;
        #3;
        check_all("reset");
        chk("reset_out_sm", 256'(out_s), 256'd0);
        chk("reset_iready_sm", 256'(in_ready_s), 256'd1);
        #9;
        rst_n = 1'b1;

        // Tile 1: k mod 16, continuous
        for (int k = 0; k < 64; k++) begin
            in_data = 4'(k % 16);
            in_valid = 1'b1;
            cyc();
            check_all("t1");
        end
        chk("t1_valid", 256'(out_valid), 256'd1);
        chk("t1_slot4", 256'(out[19:16]), 256'h1);
        chk("t1_slot41", 256'(out[167:164]), 256'hA);
        chk("t1_slot32", 256'(out[131:128]), 256'h0);
        chk("t1_s0_colmajor", out0, gold(8, 8, 8, 4, mdl));
        chk("t1_s8_colmajor", out8, gold(8, 8, 0, 4, mdl));
        cyc();
        chk("t1_pulse_end", 256'(out_valid), 256'd0);
        chk("t1_next_ready", 256'(in_ready), 256'd1);

        // Tile 2: ~30% idle cycles, then held in FULL
        out_ready = 1'b0;
        n = 0;
        while (!mfull && n < 1000) begin
            in_valid = ($urandom_range(0, 9) >= 3);
            in_data = 4'((acc * 7 + 3) % 16);
            cyc();
            check_all("t2");
            n++;
        end
        chk("t2_complete", 256'(out_valid), 256'd1);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data = 4'hC;
            cyc();
            check_all("t2_hold");
        end
        out_ready = 1'b1;
        cyc();
        chk("t2_release", 256'(in_ready), 256'd1);
        check_all("t2_rel");

        // Tile 3: flush after 20 accepts, with a coincident beat
        for (int k = 0; k < 20; k++) begin
            in_data = 4'hF;
            in_valid = 1'b1;
            cyc();
        end
        chk("t3_row_pre", 256'(row_idx), 256'd2);
        chk("t3_col_pre", 256'(col_idx), 256'd4);
        flush = 1'b1;
        in_data = 4'h5;
        cyc();
        flush = 1'b0;
        chk("flush_row", 256'(row_idx), 256'd0);
        chk("flush_col", 256'(col_idx), 256'd0);
        check_all("flush");

        // Tile 4: full tile after the flush
        for (int k = 0; k < 64; k++) begin
            in_data = 4'((k * 5 + 1) % 16);
            cyc();
        end
        check_all("t4");
        chk("t4_valid", 256'(out_valid), 256'd1);

        // Flush together with out_ready in FULL
        flush = 1'b1;
        in_data = 4'h9;
        cyc();
        flush = 1'b0;
        check_all("flush_full");
        in_data = 4'h6;
        cyc();
        chk("flush_full_col", 256'(col_idx), 256'd1);
        check_all("after_flush_full");

        // Async reset mid-tile
        for (int k = 0; k < 9; k++) begin
            in_data = 4'(k + 2);
            cyc();
        end
        check_all("pre_reset");
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 64; i++) mdl[i] = '0;
        acc = 0;
        mfull = 1'b0;
        #1;
        chk("arst_out", out, 256'd0);
        chk("arst_iready", 256'(in_ready), 256'd1);
        check_all("arst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Small variant: 3x5, SUB_ROWS=1, 7-bit
        for (int k = 0; k < 15; k++) begin
            in_data_s = 7'((k * 9 + 2) % 128);
            in_valid_s = 1'b1;
            mdls[k] = in_data_s;
            @(posedge clk);
            #1;
            if (k == 6) begin
                chk("sm_row", 256'(row_s), 256'd1);
                chk("sm_col", 256'(col_s), 256'd2);
            end
        end
        in_valid_s = 1'b0;
        chk("sm_valid", 256'(out_valid_s), 256'd1);
        chk("sm_iready", 256'(in_ready_s), 256'd0);
        chk("sm_slot5", 256'(out_s[41:35]), 256'd47);
        chk("sm_slot3", 256'(out_s[27:21]), 256'd29);
        chk("sm_out", 256'(out_s), gold(3, 5, 1, 7, mdls));
        out_ready_s = 1'b1;
        @(posedge clk);
        #1;
        chk("sm_release", 256'(in_ready_s), 256'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sub_array_stream_packer.md
# sub_array_stream_packer

Sequential front-end for the sub-row split flattening layout. It accepts a ROWS×COLS tile of BIT_WIDTH elements as a row-major stream over a valid/ready handshake. Each element is written directly into its slot of a packed ROWS*COLS*BIT_WIDTH vector: the top SUB_ROWS rows are column-major first, then the remaining rows, also column-major. The completed vector is presented to downstream consumers with a valid/ready handshake, replacing a full 3D-array staging register plus combinational reorder.

## Interface
- BIT_WIDTH, 4, element width in bits
- ROWS, 8, tile rows; ≥1
- COLS, 8, tile columns; ≥1
- SUB_ROWS, 4, rows in the first (upper) partition; 0 ≤ SUB_ROWS ≤ ROWS
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- flush  input  1  synchronous abort of the current tile
- in_data  input  BIT_WIDTH  element (r,c), row-major order
- in_valid  input  1  in_data valid
- in_ready  output  1  block accepts in_data this cycle
- out  output  ROWS*COLS*BIT_WIDTH  packed tile
- out_valid  output  1  out holds a complete tile
- out_ready  input  1  downstream accepts tile
- row_idx  output  max(1,$clog2(ROWS))  row of next element to accept
- col_idx  output  max(1,$clog2(COLS))  column of next element to accept

## Operation
- States: FILL, FULL. in_ready = (state==FILL); out_valid = (state==FULL). Both are pure state decodes, with no combinational path from inputs.
- Accept in FILL when in_valid && in_ready.
- Slot for element (r,c), r<SUB_ROWS: s = c*SUB_ROWS + r.
- Slot for element (r,c), r≥SUB_ROWS: s = COLS*SUB_ROWS + c*(ROWS-SUB_ROWS) + (r-SUB_ROWS).
- Slot placement: out[s*BIT_WIDTH +: BIT_WIDTH] ← in_data. No other bits of out change.
- Counter advance on accept: col_idx++. At col_idx==COLS-1, col_idx←0 and row_idx++.
- Last element: accepting element (ROWS-1, COLS-1) wraps both counters to 0 and moves to FULL.
- FULL: out is held stable. When out_ready=1, move to FILL. out is not cleared; the next tile overwrites every slot.
- flush=1: state←FILL and row_idx, col_idx ← 0. out is unchanged. Any in handshake that cycle is ignored, so no write and no count. Flush has priority over all other events, including completion and out handshake.
- SUB_ROWS=0: all rows use the second formula; layout is pure column-major.
- SUB_ROWS=ROWS: all rows use the first formula; layout is pure column-major.
- Slot arithmetic must not overflow: compute in ≥ $clog2(ROWS*COLS)+1 bits, or use an incrementally maintained slot pointer.

## Timing
- Reset (rst_n=0, asynchronous): state=FILL, row_idx=0, col_idx=0, out=0, out_valid=0, in_ready=1.
- One element per cycle in FILL. Write is visible on out the cycle after acceptance.
- out_valid rises the cycle after the last element is accepted. Fill-to-valid latency is 1 cycle after the ROWS*COLS-th accept.
- In FULL, in_ready=0, so no overlap between tiles.
- Tile handshake: out_ready high in FULL causes in_ready=1 on the next cycle.
- Best-case throughput: ROWS*COLS+1 cycles per tile.
- out_valid, once high, stays high with out stable until out_ready or flush.
- Reset mid-fill discards partial data. out returns to 0.

## Test plan
- Defaults, stream in_data = k mod 16 for k = r*COLS+c, in_valid always high, out_ready high:
  - out[19:16]=1, from (0,1) to slot 4.
  - out[167:164]=0xA, from (5,2), k=42, to slot 41.
  - out[131:128]=0, from (4,0), k=32, to slot 32.
  - out_valid pulses exactly 1 cycle, 1 cycle after the 64th accept.
  - Next tile accepted immediately after.
- Random in_valid gaps, 30% idle: only accepted beats advance row_idx/col_idx. Final out matches the golden reorder of the same tile.
- Backpressure: hold out_ready=0 for 10 cycles in FULL with in_valid=1. Required: in_ready=0 and out unchanged throughout. Tile completes when out_ready=1, then in_ready=1 the next cycle.
- flush after 20 accepts (row_idx=2, col_idx=4): next cycle row_idx=0, col_idx=0, out_valid=0. The following 64-element tile produces a fully correct out.
- flush in FULL, coincident with out_ready=1: returns to FILL, no double transition. in_valid coincident with flush in FILL: no write.
- Parameter sweeps, golden-compared:
  - SUB_ROWS=0 and SUB_ROWS=8 give pure column-major (element (r,c) at slot c*8+r).
  - ROWS=3, COLS=5, SUB_ROWS=1, BIT_WIDTH=7.
  - Assert rst_n=0 asynchronously mid-tile: out=0, in_ready=1 immediately.
